mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of EX and upstream of WB. Registers the EX→MEM bus under stall control and receives the synchronous data-SRAM read word one cycle after EX issued the request. It extracts and extends the loaded byte, halfword or word, and selects between load data and the ALU result. The write-back record goes to WB, and a copy goes to ID for forwarding. A one-entry read-data holding buffer preserves the SRAM word while the stage is frozen.

## Interface
Parameters (from `lib/defines.vh`):
- `EX_TO_MEM_WD`, 79 — EX→MEM bus width.
- `MEM_TO_WB_WD`, 70 — MEM→WB bus width.
- `StallBus`, 6 — stall vector width; bit 3 = MEM, bit 4 = WB.

Ports:
- **Clock and reset:** one clock; reset is asynchronous and active-high.
  - `clk` in 1 — rising-edge clock.
  - `rst` in 1 — asynchronous reset, active-high.
- `stall` in `StallBus` — pipeline stall vector.
- `ex_to_mem_bus` in 79 — bit layout:
  - `mem_op` [78:76]
  - `ex_pc` [75:44]
  - `data_ram_en` [43]
  - `data_ram_wen` [42:39]
  - `sel_rf_res` [38]
  - `rf_we` [37]
  - `rf_waddr` [36:32]
  - `ex_result` [31:0] (ALU result or data address)
- `data_sram_rdata` in 32 — SRAM read word, valid in the cycle after the EX request.
- `mem_to_wb_bus` out 70 — layout: `mem_pc` [69:38], `rf_we` [37], `rf_waddr` [36:32], `rf_wdata` [31:0].
- `mem_to_id_bus` out 70 — identical copy of `mem_to_wb_bus`, used for forwarding.

## Operation
- **Pipeline register `ex_to_mem_bus_r`** has three update cases:
  - Bubble: if `stall[3]`==Stop and `stall[4]`==NoStop, load all-zeros.
  - Advance: else if `stall[3]`==NoStop, load `ex_to_mem_bus`.
  - Hold: otherwise keep the current value.
- **Read-data buffer** consists of `rdata_buf`[31:0] and `buf_valid`:
  - Clear `buf_valid` on any bubble or advance.
  - Capture on hold: if holding and `buf_valid`==0, set `rdata_buf` to `data_sram_rdata` and `buf_valid` to 1.
  - On later hold cycles the buffer is unchanged.
  - Effective word `rdata` = `buf_valid` ? `rdata_buf` : `data_sram_rdata`.
- **Load extract**: offset `a` = `ex_result[1:0]`, little-endian. Codes for `mem_op`:
  - 000 LW: `rdata`.
  - 001 LB: `rdata[8a+7:8a]`, sign-extended.
  - 010 LBU: same byte, zero-extended.
  - 011 LH: `rdata[16*a[1]+15 : 16*a[1]]`, sign-extended.
  - 100 LHU: same halfword, zero-extended.
  - 101–111: treated as LW.
- **Halfword alignment**: `a[0]` is ignored for halfwords. Unaligned accesses are not trapped here.
- **Result select**: `rf_wdata` = (`sel_rf_res` & `data_ram_en` & `data_ram_wen`==0) ? extracted : `ex_result`.
- **Pass-through**: the two output buses are driven combinationally from the register and the extract logic. Stores pass through as records with `rf_we`=0.

## Timing
- **Reset** (async, immediate): register, `rdata_buf` and `buf_valid` all clear to 0. Both output buses read all-zero, including `rf_we`=0.
- **Latency**: one cycle from EX presenting a record to it appearing on `mem_to_wb_bus`.
- **Load data** is valid in that same cycle, with no added stall.
- **Forwarding**: `mem_to_id_bus` reflects the MEM record in the same cycle as `mem_to_wb_bus`.
- **Hold of N cycles**: the outputs are constant for all N+1 cycles, even if `data_sram_rdata` changes after the first.
- **Hold then advance**: the buffer is cleared on the advancing edge, and the next record uses live `data_sram_rdata`.
- **Hold then bubble** (`stall[4]` released while `stall[3]` is held): the register goes to zero and `buf_valid` clears.
- **Reset during a hold**: all state clears at once. No stale buffer word survives.
- **Priority**: reset > bubble > advance > hold.

## Structure
- **Constants in `lib/defines.vh`**:
  - `EX_TO_MEM_WD`, `MEM_TO_WB_WD`, `StallBus`, `Stop`/`NoStop`.
  - New load codes `MEM_LW`, `MEM_LB`, `MEM_LBU`, `MEM_LH`, `MEM_LHU`.
- **Sub-module `load_ext`**: purely combinational. Inputs `mem_op`[2:0], `addr_lo`[1:0], `rdata`[31:0]; output `ldata`[31:0]. Instantiated once.
- **Sequential logic**: the pipeline register, `rdata_buf` and `buf_valid` all live in `mem_stage`.

## Test plan
- **Reset mid-hold.** Assert `rst` asynchronously mid-cycle while the stage is holding a loaded record. Required: both buses read 0 before the next edge, and `buf_valid` reads 0.
- **Byte extract.** LB, LBU, LH and LHU with `rdata`=0x80FF7F01. Required:
  - LB with `ex_result`=0x1003 gives 0xFFFFFF80.
  - LBU with `ex_result`=0x1003 gives 0x00000080.
  - LH with `ex_result`=0x1000 gives 0x00007F01.
  - LHU with `ex_result`=0x1002 gives 0x000080FF.
  - LW gives 0x80FF7F01.
- **ALU pass-through.** A non-load record with `ex_result`=0x12345678, `rf_we`=1, `rf_waddr`=5. Required: `rf_wdata`=0x12345678 one cycle later on both buses.
- **Store.** A store record (`data_ram_wen`=4'b1111). Required: `rf_we`=0 and `rf_wdata`=`ex_result`.
- **Hold with changing SRAM data.** LW with `rdata`=0xCAFEBABE, then `stall`=6'b011111 for 3 cycles while `data_sram_rdata` changes to 0xDEADBEEF. Required: `rf_wdata` stays 0xCAFEBABE throughout and the next instruction uses live data.
- **Bubble insertion.** `stall[3]`=Stop with `stall[4]`=NoStop. Required: the next cycle shows an all-zero record, and the following record enters only when `stall[3]` releases.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared constants and record layouts for the MEM stage of the five-stage
// pipeline: bus widths, stall-vector encoding, load-type codes and packed
// structs matching the EX->MEM and MEM->WB bus bit layouts.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int StallBus     = 6;

    // Stall vector bit encoding
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Stall vector positions for this stage and the one after it
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    typedef enum logic [2:0] {
        MEM_LW  = 3'b000,
        MEM_LB  = 3'b001,
        MEM_LBU = 3'b010,
        MEM_LH  = 3'b011,
        MEM_LHU = 3'b100
    } mem_op_e;

    // Field order matches ex_to_mem_bus[78:0], MSB first
    typedef struct packed {
        logic [2:0]  mem_op;
        logic [31:0] ex_pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // Field order matches mem_to_wb_bus[69:0], MSB first
    typedef struct packed {
        logic [31:0] mem_pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

endpackage

// File: rtl/load_ext.sv
// load_ext
// Combinational load extractor: picks the byte/halfword/word addressed by
// addr_lo out of a little-endian 32-bit read word and sign- or zero-extends
// it according to mem_op. Unknown codes behave as a full-word load.
// Ports:
//   mem_op  [2:0]  load type code
//   addr_lo [1:0]  low address bits (byte offset)
//   rdata   [31:0] read word
//   ldata   [31:0] extracted and extended result
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Halfwords ignore addr_lo[0]; misalignment is not trapped here
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ldata = rdata;
        case (mem_op)
            MEM_LB:  ldata = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ldata = {24'd0, byte_sel};
            MEM_LH:  ldata = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ldata = {16'd0, half_sel};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage: registers the EX->MEM record under stall control,
// takes the synchronous data-SRAM read word one cycle after EX issued the
// request, extracts/extends load data and selects it against the ALU
// result. A one-entry buffer keeps the SRAM word stable while the stage is
// held, since the SRAM output is not guaranteed to persist.
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous reset, active-high
//   stall            pipeline stall vector (bit 3 MEM, bit 4 WB)
//   ex_to_mem_bus    record from EX
//   data_sram_rdata  SRAM read word for the record currently in MEM
//   mem_to_wb_bus    write-back record to WB
//   mem_to_id_bus    copy of the write-back record for ID forwarding
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [StallBus-1:0]      stall,
    input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_id_bus
);

    ex_to_mem_t  ex_to_mem_bus_r;
    logic [31:0] rdata_buf;
    logic        buf_valid;

    logic        bubble;
    logic        advance;
    logic [31:0] rdata;
    logic [31:0] ldata;
    logic        is_load;
    mem_to_wb_t  wb_rec;

    // Only the MEM and WB stall bits matter to this stage
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // MEM frozen while WB moves on: inject a bubble so WB does not repeat
    assign bubble  = (stall[STALL_MEM] == Stop) && (stall[STALL_WB] == NoStop);
    assign advance = !bubble && (stall[STALL_MEM] == NoStop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
            rdata_buf       <= '0;
            buf_valid       <= 1'b0;
        end else if (bubble) begin
            ex_to_mem_bus_r <= '0;
            buf_valid       <= 1'b0;
        end else if (advance) begin
            ex_to_mem_bus_r <= ex_to_mem_bus;
            buf_valid       <= 1'b0;
        end else if (!buf_valid) begin
            // First hold edge: the live word is still the right one, keep it
            rdata_buf <= data_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    assign rdata = buf_valid ? rdata_buf : data_sram_rdata;

    load_ext u_load_ext (
        .mem_op  (ex_to_mem_bus_r.mem_op),
        .addr_lo (ex_to_mem_bus_r.ex_result[1:0]),
        .rdata   (rdata),
        .ldata   (ldata)
    );

    assign is_load = ex_to_mem_bus_r.sel_rf_res
                   & ex_to_mem_bus_r.data_ram_en
                   & (ex_to_mem_bus_r.data_ram_wen == 4'b0000);

    always_comb begin
        wb_rec.mem_pc   = ex_to_mem_bus_r.ex_pc;
        wb_rec.rf_we    = ex_to_mem_bus_r.rf_we;
        wb_rec.rf_waddr = ex_to_mem_bus_r.rf_waddr;
        wb_rec.rf_wdata = is_load ? ldata : ex_to_mem_bus_r.ex_result;
    end

    assign mem_to_wb_bus = wb_rec;
    assign mem_to_id_bus = wb_rec;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [69:0] mem_to_id_bus;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [69:0] exp_q[$];

    localparam logic [5:0] RUN   = 6'b000000;
    localparam logic [5:0] HOLD  = 6'b011111;
    localparam logic [5:0] BUBL  = 6'b001000;

    typedef struct {
        logic [78:0] ex;
        logic [5:0]  stall;
        logic [31:0] rdata;
        logic [69:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [78:0] mk_ex(input logic [2:0] op, input logic [31:0] pc,
                                          input logic en, input logic [3:0] wen,
                                          input logic sel, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, waddr, res};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] wdata);
        return {pc, we, waddr, wdata};
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bv(input string name, input logic exp);
        n_checks++;
        if (dut.buf_valid !== exp) begin
            n_fail++;
            $display("FAIL %s buf_valid: got %b expected %b", name, dut.buf_valid, exp);
        end
    endtask

    // One cycle: drive at the falling edge, queue the expected MEM record
    // for this cycle, then compare both output buses shortly after.
    task automatic cyc(input logic [78:0] ex, input logic [5:0] st,
                       input logic [31:0] rd, input logic [69:0] exp, input string name);
        logic [69:0] e;
        @(negedge clk);
        ex_to_mem_bus   = ex;
        stall           = st;
        data_sram_rdata = rd;
        exp_q.push_back(exp);
        #2;
        e = exp_q.pop_front();
        chk({name, " wb"}, mem_to_wb_bus, e);
        chk({name, " id"}, mem_to_id_bus, e);
    endtask

    logic [78:0] nop;

    initial begin
        nop = '0;
        rst = 1'b1;
        stall = RUN;
        ex_to_mem_bus = '0;
        data_sram_rdata = '0;

        vecs[0]  = '{mk_ex(3'b001, 32'h100, 1, 4'h0, 1, 1, 5'd2, 32'h1003), RUN, 32'h0,
                     70'd0, "first_after_reset"};
        vecs[1]  = '{mk_ex(3'b010, 32'h104, 1, 4'h0, 1, 1, 5'd3, 32'h1003), RUN, 32'h80FF7F01,
                     mk_wb(32'h100, 1, 5'd2, 32'hFFFFFF80), "lb"};
        vecs[2]  = '{mk_ex(3'b011, 32'h108, 1, 4'h0, 1, 1, 5'd4, 32'h1000), RUN, 32'h80FF7F01,
                     mk_wb(32'h104, 1, 5'd3, 32'h00000080), "lbu"};
        vecs[3]  = '{mk_ex(3'b100, 32'h10C, 1, 4'h0, 1, 1, 5'd5, 32'h1002), RUN, 32'h80FF7F01,
                     mk_wb(32'h108, 1, 5'd4, 32'h00007F01), "lh"};
        vecs[4]  = '{mk_ex(3'b000, 32'h110, 1, 4'h0, 1, 1, 5'd6, 32'h1000), RUN, 32'h80FF7F01,
                     mk_wb(32'h10C, 1, 5'd5, 32'h000080FF), "lhu"};
        vecs[5]  = '{mk_ex(3'b000, 32'h114, 0, 4'h0, 0, 1, 5'd5, 32'h12345678), RUN, 32'h80FF7F01,
                     mk_wb(32'h110, 1, 5'd6, 32'h80FF7F01), "lw"};
        vecs[6]  = '{mk_ex(3'b000, 32'h118, 1, 4'hF, 1, 0, 5'd0, 32'h00002000), RUN, 32'h11111111,
                     mk_wb(32'h114, 1, 5'd5, 32'h12345678), "alu"};
        vecs[7]  = '{mk_ex(3'b001, 32'h11C, 1, 4'h0, 1, 1, 5'd7, 32'h00002001), RUN, 32'h00000055,
                     mk_wb(32'h118, 0, 5'd0, 32'h00002000), "store"};
        vecs[8]  = '{mk_ex(3'b110, 32'h120, 1, 4'h0, 1, 1, 5'd8, 32'h00003002), RUN, 32'h0000A500,
                     mk_wb(32'h11C, 1, 5'd7, 32'hFFFFFFA5), "lb_off1"};
        vecs[9]  = '{mk_ex(3'b000, 32'h124, 0, 4'h0, 0, 0, 5'd0, 32'h0), RUN, 32'h13579BDF,
                     mk_wb(32'h120, 1, 5'd8, 32'h13579BDF), "op110_as_lw"};
        vecs[10] = '{mk_ex(3'b011, 32'h128, 1, 4'h0, 1, 1, 5'd9, 32'h00004001), RUN, 32'h13579BDF,
                     mk_wb(32'h124, 0, 5'd0, 32'h0), "nop"};
        vecs[11] = '{nop, RUN, 32'h8001FFFE,
                     mk_wb(32'h128, 1, 5'd9, 32'hFFFFFFFE), "lh_odd_addr"};

        // Reset state
        @(negedge clk);
        chk("reset wb", mem_to_wb_bus, 70'd0);
        chk("reset id", mem_to_id_bus, 70'd0);
        chk_bv("reset", 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            cyc(vecs[i].ex, vecs[i].stall, vecs[i].rdata, vecs[i].exp, vecs[i].name);

        // Hold 3 cycles with changing SRAM data, then advance into a load
        cyc(mk_ex(3'b000, 32'h200, 1, 4'h0, 1, 1, 5'd10, 32'h40), RUN, 32'h0,
            mk_wb(32'h0, 0, 5'd0, 32'h0), "hold_pre");
        cyc(mk_ex(3'b000, 32'h204, 1, 4'h0, 1, 1, 5'd11, 32'h44), HOLD, 32'hCAFEBABE,
            mk_wb(32'h200, 1, 5'd10, 32'hCAFEBABE), "hold_c1");
        for (int k = 0; k < 2; k++) begin
            cyc(mk_ex(3'b000, 32'h204, 1, 4'h0, 1, 1, 5'd11, 32'h44), HOLD, 32'hDEADBEEF,
                mk_wb(32'h200, 1, 5'd10, 32'hCAFEBABE), "hold_mid");
            chk_bv("hold_mid", 1'b1);
        end
        cyc(mk_ex(3'b000, 32'h204, 1, 4'h0, 1, 1, 5'd11, 32'h44), RUN, 32'hDEADBEEF,
            mk_wb(32'h200, 1, 5'd10, 32'hCAFEBABE), "hold_last");
        cyc(nop, RUN, 32'hDEADBEEF, mk_wb(32'h204, 1, 5'd11, 32'hDEADBEEF), "after_hold_live");
        chk_bv("after_hold", 1'b0);

        // Bubble insertion
        cyc(mk_ex(3'b000, 32'h300, 0, 4'h0, 0, 1, 5'd12, 32'hAAAA), RUN, 32'h0,
            mk_wb(32'h0, 0, 5'd0, 32'h0), "bub_pre");
        cyc(mk_ex(3'b000, 32'h304, 0, 4'h0, 0, 1, 5'd13, 32'hBBBB), BUBL, 32'h0,
            mk_wb(32'h300, 1, 5'd12, 32'hAAAA), "bub_p");
        cyc(mk_ex(3'b000, 32'h304, 0, 4'h0, 0, 1, 5'd13, 32'hBBBB), BUBL, 32'h0,
            70'd0, "bub_zero1");
        cyc(mk_ex(3'b000, 32'h304, 0, 4'h0, 0, 1, 5'd13, 32'hBBBB), RUN, 32'h0,
            70'd0, "bub_zero2");
        cyc(nop, RUN, 32'h0, mk_wb(32'h304, 1, 5'd13, 32'hBBBB), "bub_q");

        // Hold then bubble
        cyc(mk_ex(3'b000, 32'h400, 1, 4'h0, 1, 1, 5'd14, 32'h80), RUN, 32'h0,
            mk_wb(32'h0, 0, 5'd0, 32'h0), "hb_pre");
        cyc(nop, HOLD, 32'h00001234, mk_wb(32'h400, 1, 5'd14, 32'h00001234), "hb_hold");
        cyc(nop, BUBL, 32'h00009999, mk_wb(32'h400, 1, 5'd14, 32'h00001234), "hb_buf");
        cyc(nop, RUN, 32'h00009999, 70'd0, "hb_zero");
        chk_bv("hb_zero", 1'b0);

        // Reset asserted mid-cycle during a hold
        cyc(mk_ex(3'b000, 32'h500, 1, 4'h0, 1, 1, 5'd15, 32'h90), RUN, 32'h0,
            70'd0, "rh_pre");
        cyc(nop, HOLD, 32'hFEEDFACE, mk_wb(32'h500, 1, 5'd15, 32'hFEEDFACE), "rh_c1");
        cyc(nop, HOLD, 32'h0BADF00D, mk_wb(32'h500, 1, 5'd15, 32'hFEEDFACE), "rh_c2");
        chk_bv("rh_c2", 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid wb", mem_to_wb_bus, 70'd0);
        chk("rst_mid id", mem_to_id_bus, 70'd0);
        chk_bv("rst_mid", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(nop, RUN, 32'h0BADF00D, 70'd0, "rst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
